exec_stage_mc: RTL



---
 rtl/exec_stage_mc.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/exec_stage_mc.sv
`default_nettype none
// ============================================================================
//  Module   : exec_stage_mc
//  Brief    : Execute stage with single-cycle ALU ops, a fixed-latency
//             multiplier and a bit-serial restoring divider.
//  Revision : 1.0
// ============================================================================
module exec_stage_mc #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3,
    parameter int TAG_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_op1,
    input  logic [DATA_W-1:0] alu_op2,
    input  logic [3:0]        alu_operation,
    input  logic              is_write_in,
    input  logic              is_store_in,
    input  logic              is_load_in,
    input  logic              is_branch,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic              is_write_out,
    output logic              is_store_out,
    output logic              is_load_out,
    output logic              is_branch_out,
    output logic [TAG_W-1:0]  tag_out,
    output logic              illegal_op
);

    localparam int c_SH_W  = $clog2(DATA_W);
    localparam int c_CNT_W = 7;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DIV  = 2'd2;
    localparam logic [1:0] c_HOLD = 2'd3;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLL  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SRA  = 4'd7;
    localparam logic [3:0] c_OP_SLT  = 4'd8;
    localparam logic [3:0] c_OP_SLTU = 4'd9;
    localparam logic [3:0] c_OP_MUL  = 4'd10;
    localparam logic [3:0] c_OP_DIVU = 4'd11;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [DATA_W-1:0]  r_rem;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_result;
    logic               r_illegal;
    logic [3:0]         r_flags;
    logic [TAG_W-1:0]   r_tag;

    logic               w_accept;
    logic [c_SH_W-1:0]  w_sh;
    logic [DATA_W-1:0]  w_alu_res;
    logic               w_illegal;
    logic [DATA_W-1:0]  w_prod;
    logic [DATA_W-1:0]  w_prod_in;
    logic [DATA_W:0]    w_shift;
    logic               w_ge;
    logic [DATA_W-1:0]  w_diff;
    logic [DATA_W-1:0]  w_rem_nxt;
    logic [DATA_W-1:0]  w_quo_nxt;

    assign in_ready = !rst && (r_state == c_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_sh     = alu_op2[c_SH_W-1:0];

    always_comb begin
        w_alu_res = '0;
        w_illegal = 1'b0;
        case (alu_operation)
            c_OP_ADD:  w_alu_res = alu_op1 + alu_op2;
            c_OP_SUB:  w_alu_res = alu_op1 - alu_op2;
            c_OP_AND:  w_alu_res = alu_op1 & alu_op2;
            c_OP_OR:   w_alu_res = alu_op1 | alu_op2;
            c_OP_XOR:  w_alu_res = alu_op1 ^ alu_op2;
            c_OP_SLL:  w_alu_res = alu_op1 << w_sh;
            c_OP_SRL:  w_alu_res = alu_op1 >> w_sh;
            c_OP_SRA:  w_alu_res = $signed(alu_op1) >>> w_sh;
            c_OP_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(alu_op1) < $signed(alu_op2))};
            c_OP_SLTU: w_alu_res = {{(DATA_W-1){1'b0}}, (alu_op1 < alu_op2)};
            c_OP_MUL:  w_alu_res = '0;
            c_OP_DIVU: w_alu_res = '0;
            default:   w_illegal = 1'b1;
        endcase
    end

    assign w_prod    = r_a * r_b;
    assign w_prod_in = alu_op1 * alu_op2;

    // Restoring divide step: r_a shifts dividend bits out and quotient bits in.
    // A zero divisor makes every trial subtraction succeed, so the quotient
    // naturally comes out as all ones.
    assign w_shift   = {r_rem, r_a[DATA_W-1]};
    assign w_ge      = (w_shift >= {1'b0, r_b});
    assign w_diff    = w_shift[DATA_W-1:0] - r_b;
    assign w_rem_nxt = w_ge ? w_diff : w_shift[DATA_W-1:0];
    assign w_quo_nxt = {r_a[DATA_W-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_illegal   <= 1'b0;
            r_flags     <= '0;
            r_tag       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_flags <= {is_write_in, is_store_in, is_load_in, is_branch};
                        r_tag   <= tag_in;
                        r_a     <= alu_op1;
                        r_b     <= alu_op2;
                        if (alu_operation == c_OP_MUL) begin
                            r_illegal <= 1'b0;
                            if (MUL_LAT == 1) begin
                                r_result    <= w_prod_in;
                                r_out_valid <= 1'b1;
                                r_state     <= c_HOLD;
                            end else begin
                                r_cnt       <= c_CNT_W'(MUL_LAT - 2);
                                r_out_valid <= 1'b0;
                                r_state     <= c_MUL;
                            end
                        end else if (alu_operation == c_OP_DIVU) begin
                            r_illegal   <= 1'b0;
                            r_rem       <= '0;
                            r_cnt       <= c_CNT_W'(DATA_W - 1);
                            r_out_valid <= 1'b0;
                            r_state     <= c_DIV;
                        end else begin
                            r_result    <= w_alu_res;
                            r_illegal   <= w_illegal;
                            r_out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                c_MUL: begin
                    if (r_cnt == '0) begin
                        r_result    <= w_prod;
                        r_out_valid <= 1'b1;
                        r_state     <= c_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_DIV: begin
                    r_a   <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    if (r_cnt == '0) begin
                        r_result    <= w_quo_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= c_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign out_valid     = r_out_valid;
    assign alu_result    = r_result;
    assign illegal_op    = r_illegal;
    assign is_write_out  = r_flags[3];
    assign is_store_out  = r_flags[2];
    assign is_load_out   = r_flags[1];
    assign is_branch_out = r_flags[0];
    assign tag_out       = r_tag;

endmodule
`default_nettype wire
